// File: rtl/mac_nbits.sv
//------------------------------------------------------------------------------
// Module   : mac_nbits
// Brief    : Signed N x N multiply-accumulate into a registered 2N-bit
//            accumulator. Define MAC_SATURATE_EN to saturate instead of wrap.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mac_nbits #(
    parameter int N = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic signed [N-1:0]   W,
    input  logic signed [N-1:0]   X,
    output logic signed [2*N-1:0] Out
);

    localparam int c_ACC_W = 2 * N;

    logic signed [c_ACC_W-1:0] r_acc;
    logic signed [c_ACC_W-1:0] w_prod;
    logic signed [c_ACC_W-1:0] w_next;

    // Both operands are signed, so they are sign-extended to the 2N-bit context.
    assign w_prod = W * X;

`ifdef MAC_SATURATE_EN
    localparam logic signed [c_ACC_W-1:0] c_SAT_MAX = {1'b0, {(c_ACC_W-1){1'b1}}};
    localparam logic signed [c_ACC_W-1:0] c_SAT_MIN = {1'b1, {(c_ACC_W-1){1'b0}}};

    logic [c_ACC_W:0] w_sum_ext;

    // One guard bit holds the true sum; a disagreement between the top two
    // bits means the result left the 2N-bit signed range.
    assign w_sum_ext = {r_acc[c_ACC_W-1], r_acc} + {w_prod[c_ACC_W-1], w_prod};

    always_comb begin
        w_next = w_sum_ext[c_ACC_W-1:0];
        if (w_sum_ext[c_ACC_W] != w_sum_ext[c_ACC_W-1]) begin
            w_next = w_sum_ext[c_ACC_W] ? c_SAT_MIN : c_SAT_MAX;
        end
    end
`else
    assign w_next = r_acc + w_prod;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc <= '0;
        end else if (en) begin
            r_acc <= w_next;
        end
    end

    assign Out = r_acc;

endmodule

`default_nettype wire

// File: tb/tb_mac_nbits.sv
//------------------------------------------------------------------------------
// Module   : tb_mac_nbits
// Brief    : Directed and randomised checks of mac_nbits with N = 8.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_mac_nbits;

    logic               clk;
    logic               rst;
    logic               en;
    logic signed [7:0]  W;
    logic signed [7:0]  X;
    logic signed [15:0] Out;

    int errors = 0;
    int checks = 0;

    logic signed [15:0] model;

    mac_nbits #(.N(8)) dut (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .W   (W),
        .X   (X),
        .Out (Out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply one set of inputs across a single rising edge, then settle.
    task automatic step(input logic r, input logic e, input int w, input int x);
        rst = r;
        en  = e;
        W   = 8'(w);
        X   = 8'(x);
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input int exp);
        logic signed [15:0] exp16;
        exp16 = 16'(exp);
        checks++;
        assert (Out === exp16) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, Out, exp16);
        end
    endtask

    // Independent reference for one edge using wide integer arithmetic.
    function automatic logic signed [15:0] ref_next(input logic signed [15:0] acc,
                                                    input logic r, input logic e,
                                                    input logic signed [7:0] w,
                                                    input logic signed [7:0] x);
        int s;
        if (r) return 16'sd0;
        if (!e) return acc;
        s = int'(acc) + int'(w) * int'(x);
`ifdef MAC_SATURATE_EN
        if (s > 32767)  return 16'sd32767;
        if (s < -32768) return -16'sd32768;
        return 16'(s);
`else
        return 16'(s);
`endif
    endfunction

    initial begin
        rst = 1'b0; en = 1'b0; W = '0; X = '0;
        @(negedge clk);

        // Reset then accumulate
        step(1, 0, 0, 0);        check("reset", 0);
        step(0, 1, -3, 2);       check("acc_first", -6);
        step(0, 1, 5, -4);       check("acc_second", -26);

        // Reset mid-operation and reset priority over enable
        step(1, 0, 0, 0);        check("reset_mid", 0);
        step(1, 1, 7, 7);        check("reset_priority", 0);

        // Enable hold
        step(0, 1, 5, -4);       check("hold_a", -20);
        step(0, 1, 6, -8);       check("hold_b", -68);
        for (int i = 0; i < 4; i++) begin
            step(0, 0, -8, -4);  check("hold_idle", -68);
        end

        // Extreme operands
        step(1, 0, 0, 0);        check("reset_ext", 0);
        step(0, 1, -128, -128);  check("ext_negneg", 16384);
        step(0, 1, 127, -128);   check("ext_posneg", 128);

        // Positive overflow
        step(1, 0, 0, 0);        check("reset_ovf", 0);
        step(0, 1, -128, -128);  check("ovf_first", 16384);
        step(0, 1, -128, -128);
`ifdef MAC_SATURATE_EN
        check("ovf_pos_sat", 32767);
        step(0, 1, -128, -128);  check("ovf_pos_stay", 32767);
`else
        check("ovf_pos_wrap", -32768);
        step(0, 1, -128, -128);  check("ovf_pos_wrap2", -16384);
`endif

        // Negative overflow: 3 * -16256 = -48768
        step(1, 0, 0, 0);        check("reset_neg", 0);
        step(0, 1, 127, -128);   check("neg_1", -16256);
        step(0, 1, 127, -128);   check("neg_2", -32512);
        step(0, 1, 127, -128);
`ifdef MAC_SATURATE_EN
        check("neg_sat", -32768);
`else
        check("neg_wrap", 16768);
`endif

        // Randomised regression against the reference function
        step(1, 0, 0, 0);        check("reset_rand", 0);
        model = '0;
        for (int i = 0; i < 1000; i++) begin
            logic r, e;
            logic [7:0] wr, xr;
            r  = ($urandom_range(31) == 0);
            e  = ($urandom_range(3) != 0);
            wr = 8'($urandom_range(255));
            xr = 8'($urandom_range(255));
            model = ref_next(model, r, e, wr, xr);
            step(r, e, int'($signed(wr)), int'($signed(xr)));
            check("random", int'(model));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
